// File: rtl/vs_uart_tx.sv
// UART frame transmitter: start, 8 data bits LSB first, parity, stop.
// Can invert the parity bit or clear the stop bit of a frame to exercise peer error checks.
module vs_uart_tx #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       CLK,
  input  logic       SYS_NRST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  input  logic       GEN_PAR_ERR,
  input  logic       GEN_FRT_ERR,
  output logic       TX_RDY,
  output logic       TX_DONE,
  output logic       TXD
);

  localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [7:0]         r_data;
  logic               r_par_err;
  logic               r_frt_err;
  logic               r_txd;
  logic               r_rdy;
  logic               r_done;
  logic               w_txd_nxt;
  logic               w_done_nxt;
  logic               w_load;
  logic               w_tick;

  assign w_tick = (r_cnt == CNT_W'(BAUD_DIV - 1));

  // Next-state, counters and registered-output values
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_txd_nxt   = 1'b1;

    if (r_state == S_IDLE) begin
      w_cnt_nxt = '0;
      w_idx_nxt = '0;
      if (TX_VALID && r_rdy) begin
        w_state_nxt = S_START;
        w_load      = 1'b1;
      end
    end else if (!w_tick) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = '0;
      unique case (r_state)
        S_START: begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = '0;
        end
        S_DATA: begin
          if (r_idx == IDX_W'(7)) begin
            w_state_nxt = S_PARITY;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    unique case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = r_data[w_idx_nxt];
      S_PARITY: w_txd_nxt = (^r_data) ^ PARITY_ODD ^ r_par_err;
      S_STOP:   w_txd_nxt = ~r_frt_err;
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_par_err <= 1'b0;
      r_frt_err <= 1'b0;
      r_txd     <= 1'b1;
      r_rdy     <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_txd   <= w_txd_nxt;
      r_rdy   <= (w_state_nxt == S_IDLE);
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_data    <= TX_DATA;
        r_par_err <= GEN_PAR_ERR;
        r_frt_err <= GEN_FRT_ERR;
      end
    end
  end

  assign TXD     = r_txd;
  assign TX_RDY  = r_rdy;
  assign TX_DONE = r_done;

endmodule

// File: tb/tb_vs_uart_tx.sv
// Self-checking bench for vs_uart_tx: table vectors, hand sequences and random frames
// compared against a per-bit frame model; even and odd parity instances share the clock.
module tb_vs_uart_tx;

  localparam int unsigned B = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_e, data_o;
  logic       valid_e, valid_o;
  logic       pe_e, pe_o, fe_e, fe_o;
  logic       rdy_e, rdy_o, done_e, done_o, txd_e, txd_o;

  int n_cmp;
  int n_err;

  vs_uart_tx #(.BAUD_DIV(B), .PARITY_ODD(1'b0)) dut_e (
    .CLK(clk), .SYS_NRST(rst_n), .TX_DATA(data_e), .TX_VALID(valid_e),
    .GEN_PAR_ERR(pe_e), .GEN_FRT_ERR(fe_e),
    .TX_RDY(rdy_e), .TX_DONE(done_e), .TXD(txd_e)
  );

  vs_uart_tx #(.BAUD_DIV(B), .PARITY_ODD(1'b1)) dut_o (
    .CLK(clk), .SYS_NRST(rst_n), .TX_DATA(data_o), .TX_VALID(valid_o),
    .GEN_PAR_ERR(pe_o), .GEN_FRT_ERR(fe_o),
    .TX_RDY(rdy_o), .TX_DONE(done_o), .TXD(txd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    bit         odd;
    logic       exp_par;
    logic       exp_stop;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_txd(input bit sel);
    return sel ? txd_o : txd_e;
  endfunction

  function automatic logic get_rdy(input bit sel);
    return sel ? rdy_o : rdy_e;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? done_o : done_e;
  endfunction

  // Frame model: line level of each of the 11 bit slots
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic pe,
                                             input logic fe, input bit odd);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(d[k]);
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = d[k];
    f[9]  = 1'((ones % 2) == 1) ^ 1'(odd) ^ pe;
    f[10] = ~fe;
    return f;
  endfunction

  task automatic drive(input bit sel, input logic [7:0] d, input logic pe,
                       input logic fe, input logic v);
    if (sel) begin
      data_o = d; pe_o = pe; fe_o = fe; valid_o = v;
    end else begin
      data_e = d; pe_e = pe; fe_e = fe; valid_e = v;
    end
  endtask

  // Present a byte at a falling edge and let the next rising edge accept it
  task automatic start(input bit sel, input logic [7:0] d, input logic pe,
                       input logic fe, input bit keep);
    int waited;
    waited = 0;
    while (!get_rdy(sel) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("rdy_before_accept", 32'(get_rdy(sel)), 32'd1);
    drive(sel, d, pe, fe, 1'b1);
    @(posedge clk);
    #1;
    if (!keep) drive(sel, $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
  endtask

  // Follow one frame from the accept edge through the TX_DONE cycle
  task automatic check_frame(input bit sel, input logic [7:0] d, input logic pe,
                             input logic fe, input bit chg, input logic [7:0] chg_d,
                             output logic par_seen, output logic stop_seen);
    logic [10:0] f;
    bit odd;
    odd = sel;
    f = frame_bits(d, pe, fe, odd);
    par_seen  = 1'bx;
    stop_seen = 1'bx;
    for (int t = 1; t <= 11 * int'(B); t++) begin
      @(negedge clk);
      if (chg && t == 20) begin
        if (sel) data_o = chg_d; else data_e = chg_d;
      end
      chk("txd_bit", 32'(get_txd(sel)), 32'(f[(t-1)/int'(B)]));
      chk("rdy_busy", 32'(get_rdy(sel)), 32'd0);
      chk("done_busy", 32'(get_done(sel)), 32'd0);
      if (t == 9 * int'(B) + 1)  par_seen  = get_txd(sel);
      if (t == 10 * int'(B) + 1) stop_seen = get_txd(sel);
    end
    @(negedge clk);
    chk("txd_end", 32'(get_txd(sel)), 32'd1);
    chk("rdy_end", 32'(get_rdy(sel)), 32'd1);
    chk("done_end", 32'(get_done(sel)), 32'd1);
  endtask

  initial begin
    logic p, s;
    logic [7:0] rd;
    logic rpe, rfe;
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_txd_e", 32'(txd_e), 32'd1);
    chk("reset_rdy_e", 32'(rdy_e), 32'd1);
    chk("reset_done_e", 32'(done_e), 32'd0);
    chk("reset_txd_o", 32'(txd_o), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors, back-to-back where the same instance follows itself
    for (int i = 0; i < 7; i++) begin
      start(vecs[i].odd, vecs[i].data, vecs[i].pe, vecs[i].fe, 1'b0);
      check_frame(vecs[i].odd, vecs[i].data, vecs[i].pe, vecs[i].fe, 1'b0, 8'h00, p, s);
      chk($sformatf("vec%0d_parity", i), 32'(p), 32'(vecs[i].exp_par));
      chk($sformatf("vec%0d_stop", i), 32'(s), 32'(vecs[i].exp_stop));
    end

    // TX_VALID held high, data changed mid-frame; second byte accepted at the RDY cycle
    start(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    check_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA3, p, s);
    chk("hold_first_parity", 32'(p), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 8'h00, p, s);
    chk("hold_second_parity", 32'(p), 32'd0);
    chk("hold_second_stop", 32'(s), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done_e), 32'd0);

    // Reset during data bit 3
    start(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (18) @(negedge clk);
    chk("pre_reset_txd_bit3", 32'(txd_e), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_txd", 32'(txd_e), 32'd1);
    chk("midreset_rdy", 32'(rdy_e), 32'd1);
    chk("midreset_done", 32'(done_e), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_idle_txd", 32'(txd_e), 32'd1);
      chk("post_reset_no_done", 32'(done_e), 32'd0);
    end
    start(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, p, s);
    chk("after_reset_parity", 32'(p), 32'd0);
    chk("after_reset_stop", 32'(s), 32'd1);

    // Random frames on both instances with random idle gaps
    for (int i = 0; i < 16; i++) begin
      bit sel;
      sel = 1'($urandom_range(0, 1));
      rd  = 8'($urandom_range(0, 255));
      rpe = 1'($urandom_range(0, 1));
      rfe = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start(sel, rd, rpe, rfe, 1'b0);
      check_frame(sel, rd, rpe, rfe, 1'b0, 8'h00, p, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vs_uart_tx.md
Name: vs_uart_tx

Overview:
UART frame transmitter; the transmit-side counterpart of the receive path and its error-injection stage. It takes one byte per handshake and serialises it as: start bit, 8 data bits LSB first, one parity bit, one stop bit. It can deliberately corrupt the parity bit or the stop bit of a frame, so a peer receiver's parity and framing checks can be exercised. It sits between the controller FSM's TX data/ready handshake and the UART_TXD pin.

Parameters:
BAUD_DIV, 434, CLK cycles per bit (50 MHz / 115200); legal range >= 2.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
CLK  input  1  system clock
SYS_NRST  input  1  asynchronous, active-low reset
TX_DATA  input  8  byte to send; sampled on accept
TX_VALID  input  1  request to send TX_DATA
GEN_PAR_ERR  input  1  invert the parity bit of the frame being accepted; sampled on accept
GEN_FRT_ERR  input  1  drive the stop bit of the frame being accepted as 0; sampled on accept
TX_RDY  output  1  high = idle, able to accept a byte
TX_DONE  output  1  one-cycle pulse when a frame's stop bit completes
TXD  output  1  serial line, idle high, registered

Behaviour:
- Reset (SYS_NRST=0):
  - Takes effect immediately, asynchronously.
  - Outputs: TXD=1, TX_RDY=1, TX_DONE=0.
  - State: state=IDLE, baud counter=0, bit index=0.
- Accept: happens on a rising edge where TX_VALID && TX_RDY.
  - Latch TX_DATA, GEN_PAR_ERR and GEN_FRT_ERR into internal registers.
  - TX_RDY goes low from the next cycle.
  - TX_VALID while TX_RDY=0 is ignored. There is no queue, and the latched data and flags do not change mid-frame.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: TXD=1.
  - START: TXD=0.
  - DATA: TXD=data[bit_idx], bit_idx 0..7.
  - PARITY: TXD = (^data) ^ PARITY_ODD ^ par_err_latched.
  - STOP: TXD = ~frt_err_latched.
- Bit timing:
  - The baud counter runs 0..BAUD_DIV-1 and clears on accept and on every bit boundary.
  - The state (or bit_idx) advances when the counter = BAUD_DIV-1.
  - DATA -> PARITY when bit_idx=7 and the counter is at terminal count; bit_idx then wraps to 0.
- Cycle-level timing, with accept at edge E0:
  - TXD is low for cycles E0+1 .. E0+B, where B = BAUD_DIV.
  - Data bit k occupies cycles E0+(k+1)B+1 .. E0+(k+2)B.
  - The parity bit starts at cycle E0+9B+1.
  - The stop bit occupies cycles E0+10B+1 .. E0+11B.
  - At edge E0+11B: TX_RDY=1, TX_DONE=1 for one cycle, TXD=1.
- Throughput:
  - A back-to-back accept is possible on that same TX_RDY cycle.
  - Minimum frame period is 11B+1 cycles (one idle-high cycle between frames).
- TXD and TX_RDY are registered; nothing goes combinationally from input to output.
- Error flags apply per frame only. The next frame uses the values sampled at its own accept.
- Reset mid-frame:
  - The frame is abandoned with no TX_DONE.
  - After release the block is idle, and the next accept sends a complete frame.

Test Plan:
1. BAUD_DIV=4, even parity, TX_DATA=0x55 -> TXD sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,P=0,1. TX_RDY low for 44 cycles; TX_DONE pulses at E0+44.
2. TX_DATA=0x07 with GEN_PAR_ERR=1 -> parity bit 0 (nominal 1); all other bits correct; stop=1.
3. TX_DATA=0x41 with GEN_FRT_ERR=1, then 0x41 with flags 0 -> first stop bit 0, second stop bit 1; parity 0 in both frames.
4. TX_VALID held high, TX_DATA changed to 0xA3 mid-frame of 0x3C -> first frame transmits 0x3C unchanged; 0xA3 is accepted at the TX_RDY cycle; the second start bit begins 1 idle cycle after the first stop bit.
5. Assert SYS_NRST=0 during data bit 3 -> TXD=1 in the same cycle, TX_RDY=1, no TX_DONE. After release, 0xFF sends a full correct frame with P=0 and stop=1.
6. PARITY_ODD=1, TX_DATA=0x00 -> parity bit 1. With TX_DATA=0x01 -> parity bit 0.
